pwm_multichannel: RTL and testbench
===================================

# pwm_multichannel

Parametrised multi-channel PWM generator, successor to the fixed 16-output, 8-bit peripheral in the TinyTapeout onboarding design. It drives NUM_CH outputs from one shared frame counter with a programmable period, per-channel duty and enables, and double-buffered (shadowed) configuration that takes effect only on frame boundaries, so outputs never glitch. It sits between the register/SPI front end (which drives the cfg_* inputs) and the uo_out/uio_out pins.

## Interface
- NUM_CH, 16: number of output channels (1–32).
- CNT_W, 8: counter, period and duty width (4–16).
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  global run; low holds counter at 0 and forces out to 0.
- cfg_load  in  1  one-cycle strobe: capture all cfg_* into shadow registers.
- cfg_period  in  CNT_W  last counter value of a frame (P).
- cfg_duty  in  NUM_CH*CNT_W  per-channel duty D[i], channel i at bits [i*CNT_W +: CNT_W].
- cfg_en_out  in  NUM_CH  per-channel output enable.
- cfg_en_pwm  in  NUM_CH  per-channel PWM enable (0 = static high when output enabled).
- out  out  NUM_CH  registered PWM outputs.
- frame_start  out  1  one-cycle pulse coincident with counter = 0 at frame start.
- cfg_pending  out  1  shadow holds values not yet applied.

## Operation
- Three register sets: shadow (written by cfg_load), active (used by counter/compare), counter cnt.
- cfg_load: shadow <= cfg_*; cfg_pending <= 1.
- Transfer: on the last cycle of a frame, if cfg_pending, active <= shadow and cfg_pending <= 0.
- Simultaneous cfg_load and transfer: active gets the pre-load shadow, shadow gets new values, cfg_pending stays 1 (new values apply next frame).
- Edge-aligned counting: cnt 0,1,…,P then wraps to 0; frame = P+1 cycles. P = 0: cnt stays 0, frame = 1 cycle.
- Compare per channel: next out[i] = en_out[i] & (en_pwm[i] ? (cnt < D[i]) : 1), using active values. Comparison unsigned, CNT_W bits.
- D[i] = 0: always low. D[i] > P: always high. Duty fraction = D[i]/(P+1).
- enable low: cnt <= 0, out <= 0, frame_start <= 0; shadow loads still accepted; no transfers. Any pending config transfers on the first clock after enable rises; that edge also starts a frame.
- Reset: cnt = 0, out = 0, frame_start = 0, cfg_pending = 0, all shadow/active duty = 0, enables = 0, period = all ones (2^CNT_W − 1).

## Timing
- out is registered: out at edge t+1 reflects cnt and active values present during cycle t (1-cycle compare latency).
- frame_start asserted for exactly one cycle in the cycle where cnt = 0 after a wrap or after enable rise; never in reset; continuously high when P = 0 and enabled.
- cfg_load to visible output change: at most one full frame + 2 cycles.
- cfg_pending rises the cycle after cfg_load and falls the cycle after the transfer edge.
- rst asserted mid-frame: all outputs go to reset values immediately (asynchronous), pending config is discarded.

## Configuration
- PWM_CENTER_ALIGN_EN defined: counter runs up/down 0,1,…,P,P−1,…,1 then 0; frame = 2P cycles (P = 0: 1 cycle). Compare rule unchanged (cnt < D[i]), giving symmetric pulses centred on cnt = 0; last cycle of frame (for transfer) is the down-count cycle with cnt = 1. Direction register resets to up.
- Undefined: edge-aligned counting only; no direction register.

## Test plan
- Reset then enable=1, no load (NUM_CH=4, CNT_W=8) -> out = 0000, frame_start every 256 cycles, cfg_pending = 0.
- Load P=9, D0=3, D1=0, D2=10, D3=5, en_out=1111, en_pwm=1111 -> after transfer, per 10-cycle frame: ch0 high 3, ch1 always low, ch2 always high, ch3 high 5; cfg_pending clears at frame boundary.
- Mid-frame load of D0=7 while P=9 running -> current frame unchanged; ch0 high 7 cycles starting next frame; no short/long pulse at the boundary.
- cfg_load coinciding with last frame cycle while a previous load pending -> older values apply at that boundary, newer at following one; cfg_pending stays 1 in between.
- en_pwm[1]=0, en_out[1]=1 and en_out[2]=0 -> out[1] constant 1, out[2] constant 0; enable dropped mid-frame -> out = 0 next cycle, cnt restarts at 0 with frame_start on re-enable.
- With PWM_CENTER_ALIGN_EN, P=4, D0=2 -> cnt sequence 0,1,2,3,4,3,2,1 repeating; out[0] high for cnt 0,1 and 1 (3 of 8 cycles, centred on cnt 0); rst asserted mid-frame -> out = 0 immediately.

Source files
------------

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM: shared frame counter, shadowed config applied on frame boundaries; out lags cnt by 1 cycle.
// No backpressure: cfg_load always accepted. Define PWM_CENTER_ALIGN_EN for up/down (centre-aligned) counting.
module pwm_multichannel #(
  parameter int NUM_CH = 16,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    cfg_load,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic [NUM_CH*CNT_W-1:0] cfg_duty,
  input  logic [NUM_CH-1:0]       cfg_en_out,
  input  logic [NUM_CH-1:0]       cfg_en_pwm,
  output logic [NUM_CH-1:0]       out,
  output logic                    frame_start,
  output logic                    cfg_pending
);

  typedef struct packed {
    logic [CNT_W-1:0]        period;
    logic [NUM_CH*CNT_W-1:0] duty;
    logic [NUM_CH-1:0]       en_out;
    logic [NUM_CH-1:0]       en_pwm;
  } cfg_t;

  cfg_t              sh_q, sh_d, act_q, act_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] out_q, out_d, cmp;
  logic              fs_q, fs_d, pend_q, pend_d, run_q, run_d;
  logic              last, start;
`ifdef PWM_CENTER_ALIGN_EN
  logic              dir_q, dir_d;  // 1 = counting down
`endif

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cmp[i] = act_q.en_out[i] &
               (act_q.en_pwm[i] ? (cnt_q < act_q.duty[i*CNT_W +: CNT_W]) : 1'b1);
    end
  end

`ifdef PWM_CENTER_ALIGN_EN
  always_comb begin
    if (act_q.period == '0)
      last = 1'b1;
    else if (!dir_q)
      last = (act_q.period == CNT_W'(1)) && (cnt_q >= act_q.period);
    else
      last = (cnt_q <= CNT_W'(1));
  end
`else
  assign last = (cnt_q >= act_q.period);
`endif

  // The first enabled edge after an idle period also opens a frame.
  assign start = enable & (~run_q | last);

  always_comb begin
    cnt_d  = cnt_q;
    out_d  = '0;
    fs_d   = 1'b0;
    pend_d = pend_q;
    sh_d   = sh_q;
    act_d  = act_q;
    run_d  = enable;
`ifdef PWM_CENTER_ALIGN_EN
    dir_d  = dir_q;
`endif
    if (!enable) begin
      cnt_d = '0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_d = 1'b0;
`endif
    end else begin
      out_d = run_q ? cmp : '0;
      if (start) begin
        cnt_d = '0;
        fs_d  = 1'b1;
`ifdef PWM_CENTER_ALIGN_EN
        dir_d = 1'b0;
`endif
        if (pend_q) begin
          act_d  = sh_q;
          pend_d = 1'b0;
        end
      end else begin
`ifdef PWM_CENTER_ALIGN_EN
        if (dir_q) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (cnt_q >= act_q.period) begin
          cnt_d = cnt_q - CNT_W'(1);
          dir_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        cnt_d = cnt_q + CNT_W'(1);
`endif
      end
    end
    // A load on the transfer edge lands in shadow after active took the old shadow.
    if (cfg_load) begin
      sh_d   = '{period: cfg_period, duty: cfg_duty, en_out: cfg_en_out, en_pwm: cfg_en_pwm};
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      out_q  <= '0;
      fs_q   <= 1'b0;
      pend_q <= 1'b0;
      run_q  <= 1'b0;
      sh_q   <= '{period: '1, duty: '0, en_out: '0, en_pwm: '0};
      act_q  <= '{period: '1, duty: '0, en_out: '0, en_pwm: '0};
`ifdef PWM_CENTER_ALIGN_EN
      dir_q  <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      fs_q   <= fs_d;
      pend_q <= pend_d;
      run_q  <= run_d;
      sh_q   <= sh_d;
      act_q  <= act_d;
`ifdef PWM_CENTER_ALIGN_EN
      dir_q  <= dir_d;
`endif
    end
  end

  assign out         = out_q;
  assign frame_start = fs_q;
  assign cfg_pending = pend_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Bench for pwm_multichannel (4 channels, 8-bit): table vectors, corner sequences, random vs frame-position model.
module tb_pwm_multichannel;
  localparam int NCH = 4;
  localparam int CW  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              cfg_load;
  logic [CW-1:0]     cfg_period;
  logic [NCH*CW-1:0] cfg_duty;
  logic [NCH-1:0]    cfg_en_out;
  logic [NCH-1:0]    cfg_en_pwm;
  logic [NCH-1:0]    out;
  logic              frame_start;
  logic              cfg_pending;

  pwm_multichannel #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_load(cfg_load),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty), .cfg_en_out(cfg_en_out),
    .cfg_en_pwm(cfg_en_pwm), .out(out), .frame_start(frame_start),
    .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  p;
    logic [31:0] d;
    logic [3:0]  eo;
    logic [3:0]  ep;
  } mcfg_t;

  typedef struct packed {
    logic [7:0]  p;
    logic [31:0] d;
    logic [3:0]  eo;
    logic [3:0]  ep;
    logic [63:0] hi;   // expected high cycles per frame, edge-aligned, 16 bits per channel
  } vec_t;

  int checks = 0;
  int errors = 0;

  mcfg_t       m_sh, m_act;
  bit          m_pend, m_run, e_fs;
  int          m_pos;
  logic [3:0]  e_out;

  function automatic int flen(input logic [7:0] p);
`ifdef PWM_CENTER_ALIGN_EN
    return (p == 0) ? 1 : 2 * int'(p);
`else
    return int'(p) + 1;
`endif
  endfunction

  function automatic int cnt_at(input int pos, input logic [7:0] p);
`ifdef PWM_CENTER_ALIGN_EN
    return (pos <= int'(p)) ? pos : 2 * int'(p) - pos;
`else
    return pos;
`endif
  endfunction

  function automatic logic [3:0] ideal(input int c, input mcfg_t a);
    logic [3:0] r;
    for (int i = 0; i < NCH; i++)
      r[i] = a.eo[i] && (!a.ep[i] || (c < int'(a.d[i*8 +: 8])));
    return r;
  endfunction

  function automatic int exp_hi(input vec_t v, input int ch);
`ifdef PWM_CENTER_ALIGN_EN
    int dd;
    dd = int'(v.d[ch*8 +: 8]);
    if (!v.eo[ch]) return 0;
    if (!v.ep[ch] || dd > int'(v.p)) return flen(v.p);
    if (dd == 0) return 0;
    return 2 * dd - 1;
`else
    return int'(v.hi[ch*16 +: 16]);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sh   = '{p: 8'hFF, d: '0, eo: '0, ep: '0};
    m_act  = m_sh;
    m_pend = 0;
    m_run  = 0;
    m_pos  = 0;
    e_out  = '0;
    e_fs   = 0;
  endtask

  // Advances the model across one rising edge using the inputs the DUT will sample.
  task automatic model_step();
    int fl;
    if (!enable) begin
      e_out = '0; e_fs = 0; m_pos = 0; m_run = 0;
    end else begin
      fl    = flen(m_act.p);
      e_out = m_run ? ideal(cnt_at(m_pos, m_act.p), m_act) : 4'b0;
      if (!m_run || m_pos >= fl - 1) begin
        if (m_pend) begin m_act = m_sh; m_pend = 0; end
        m_pos = 0; e_fs = 1;
      end else begin
        m_pos++; e_fs = 0;
      end
      m_run = 1;
    end
    if (cfg_load) begin
      m_sh   = '{p: cfg_period, d: cfg_duty, eo: cfg_en_out, ep: cfg_en_pwm};
      m_pend = 1;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("out", 32'(out), 32'(e_out));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("cfg_pending", 32'(cfg_pending), 32'(m_pend));
  endtask

  task automatic drive_cfg(input logic [7:0] p, input logic [31:0] d,
                           input logic [3:0] eo, input logic [3:0] ep);
    cfg_period = p; cfg_duty = d; cfg_en_out = eo; cfg_en_pwm = ep;
  endtask

  task automatic load_cfg(input logic [7:0] p, input logic [31:0] d,
                          input logic [3:0] eo, input logic [3:0] ep);
    drive_cfg(p, d, eo, ep);
    cfg_load = 1'b1;
    cycle();
    cfg_load = 1'b0;
  endtask

  task automatic wait_pending_clear(input string name, output int n);
    n = 0;
    while (cfg_pending === 1'b1 && n < 1200) begin
      cycle();
      n++;
    end
    if (cfg_pending !== 1'b0) chk({name, "_timeout"}, 32'(cfg_pending), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[6];

  initial begin
    int first, second, n, hc[4], fsn;

    vecs[0] = '{p: 8'd9,  d: {8'd5, 8'd10, 8'd0, 8'd3},  eo: 4'hF,    ep: 4'hF,    hi: {16'd5, 16'd10, 16'd0, 16'd3}};
    vecs[1] = '{p: 8'd9,  d: {8'd5, 8'd10, 8'd0, 8'd7},  eo: 4'hF,    ep: 4'hF,    hi: {16'd5, 16'd10, 16'd0, 16'd7}};
    vecs[2] = '{p: 8'd4,  d: {8'd9, 8'd1, 8'd4, 8'd2},   eo: 4'b1011, ep: 4'b1101, hi: {16'd5, 16'd0, 16'd5, 16'd2}};
    vecs[3] = '{p: 8'd0,  d: {8'd0, 8'd5, 8'd1, 8'd0},   eo: 4'hF,    ep: 4'b0111, hi: {16'd1, 16'd1, 16'd1, 16'd0}};
    vecs[4] = '{p: 8'd15, d: {8'd1, 8'd15, 8'd16, 8'd8}, eo: 4'hF,    ep: 4'hF,    hi: {16'd1, 16'd15, 16'd16, 16'd8}};
    vecs[5] = '{p: 8'd3,  d: {8'd4, 8'd3, 8'd2, 8'd1},   eo: 4'b0110, ep: 4'hF,    hi: {16'd0, 16'd3, 16'd2, 16'd0}};

    rst = 1'b1; enable = 1'b0; cfg_load = 1'b0;
    drive_cfg(8'd0, 32'd0, 4'd0, 4'd0);
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_pending", 32'(cfg_pending), 32'd0);
    rst = 1'b0;

    // Default period after reset: frame length 2^CNT_W (edge) with all outputs low.
    enable = 1'b1;
    first = -1; second = -1;
    for (int i = 0; i < 1200 && second < 0; i++) begin
      cycle();
      if (frame_start === 1'b1) begin
        if (first < 0) first = i; else second = i;
      end
    end
    chk("default_frame_len", 32'(second - first), 32'(flen(8'hFF)));

    for (int v = 0; v < 6; v++) begin
      load_cfg(vecs[v].p, vecs[v].d, vecs[v].eo, vecs[v].ep);
      chk($sformatf("vec%0d_pending_set", v), 32'(cfg_pending), 32'd1);
      wait_pending_clear($sformatf("vec%0d", v), n);
      chk($sformatf("vec%0d_fs_at_xfer", v), 32'(frame_start), 32'd1);
      for (int c = 0; c < 4; c++) hc[c] = 0;
      fsn = 0;
      for (int k = 0; k < flen(vecs[v].p); k++) begin
        cycle();
        for (int c = 0; c < 4; c++) hc[c] += int'(out[c]);
        fsn += int'(frame_start);
      end
      for (int c = 0; c < 4; c++)
        chk($sformatf("vec%0d_ch%0d_high", v, c), 32'(hc[c]), 32'(exp_hi(vecs[v], c)));
      chk($sformatf("vec%0d_fs_per_frame", v), 32'(fsn), 32'd1);
    end

    // Load A mid-frame, then load B exactly on A's transfer edge.
    load_cfg(8'd9, {8'd1, 8'd2, 8'd3, 8'd4}, 4'hF, 4'hF);
    n = 0;
    while (!(m_pos == flen(m_act.p) - 1) && n < 600) begin cycle(); n++; end
    chk("coincide_reached_last", 32'(m_pos), 32'(flen(m_act.p) - 1));
    load_cfg(8'd5, {8'd6, 8'd5, 8'd4, 8'd3}, 4'hF, 4'hF);
    chk("coincide_pending_held", 32'(cfg_pending), 32'd1);
    chk("coincide_fs", 32'(frame_start), 32'd1);
    wait_pending_clear("coincide", n);
    chk("coincide_pending_span", 32'(n), 32'(flen(8'd9)));
    repeat (8) cycle();

    // Drop enable mid-frame, load while idle, re-enable.
    repeat (3) cycle();
    enable = 1'b0;
    cycle();
    chk("disable_out", 32'(out), 32'd0);
    chk("disable_fs", 32'(frame_start), 32'd0);
    load_cfg(8'd7, {8'd8, 8'd0, 8'd2, 8'd5}, 4'b1101, 4'b1011);
    chk("idle_pending", 32'(cfg_pending), 32'd1);
    repeat (2) cycle();
    chk("idle_pending_kept", 32'(cfg_pending), 32'd1);
    enable = 1'b1;
    cycle();
    chk("reenable_fs", 32'(frame_start), 32'd1);
    chk("reenable_pending", 32'(cfg_pending), 32'd0);
    repeat (20) cycle();

    for (int r = 0; r < 600; r++) begin
      enable   = ($urandom_range(0, 15) != 0);
      cfg_load = ($urandom_range(0, 9) == 0);
      drive_cfg(8'($urandom_range(0, 12)), $urandom, 4'($urandom), 4'($urandom));
      for (int c = 0; c < 4; c++) cfg_duty[c*8 +: 8] = 8'($urandom_range(0, 15));
      cycle();
    end
    cfg_load = 1'b0;
    enable   = 1'b1;

    // Asynchronous reset between edges with static-high outputs and a pending load.
    load_cfg(8'd6, 32'd0, 4'hF, 4'h0);
    wait_pending_clear("pre_rst", n);
    repeat (3) cycle();
    load_cfg(8'd3, 32'h01020304, 4'hF, 4'hF);
    chk("pre_rst_out", 32'(out), 32'hF);
    chk("pre_rst_pending", 32'(cfg_pending), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", 32'(out), 32'd0);
    chk("async_rst_fs", 32'(frame_start), 32'd0);
    chk("async_rst_pending", 32'(cfg_pending), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (12) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
